// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS BCD time counter.
//   state_e   : control FSM encoding (STOP, RUN, LOAD)
//   BCD_59    : last value of the seconds/minutes fields
//   BCD_ZERO  : wrap / reset value of every field
//   to_bcd8   : small integer to packed two-digit BCD
//   bcd_le    : checks a byte is valid BCD and not above a BCD limit
package clock_pkg;

    localparam int unsigned BCD_W = 8;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam logic [BCD_W-1:0] BCD_59   = 8'h59;
    localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;

    function automatic logic [BCD_W-1:0] to_bcd8(input int unsigned v);
        return 8'((((v / 10) % 10) * 16) + (v % 10));
    endfunction

    // Valid BCD compares correctly as plain binary, so one magnitude test suffices.
    function automatic logic bcd_le(input logic [BCD_W-1:0] val, input logic [BCD_W-1:0] max);
        return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= max);
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit packed BCD counter with synchronous load and wrap at i_max_val.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : advance by one (ignored while i_load)
//   i_load         : write i_load_val
//   i_max_val      : last value before wrapping to 00
//   o_value        : registered count
//   o_wrap_c       : combinational, high when this increment wraps to 00
module bcd_digit_pair
    import clock_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic [BCD_W-1:0] i_max_val,
    output logic [BCD_W-1:0] o_value,
    output logic             o_wrap_c
);

    logic [BCD_W-1:0] r_value;
    logic [BCD_W-1:0] w_next;
    logic             w_at_max;

    assign w_at_max = (r_value == i_max_val);
    assign o_wrap_c = i_inc & w_at_max;
    assign o_value  = r_value;

    // Next BCD value: wrap, decimal carry into the tens digit, or plain +1.
    always_comb begin
        w_next = r_value;
        if (w_at_max) begin
            w_next = BCD_ZERO;
        end else if (r_value[3:0] == 4'd9) begin
            w_next = {r_value[7:4] + 4'd1, 4'd0};
        end else begin
            w_next = {r_value[7:4], r_value[3:0] + 4'd1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= BCD_ZERO;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/time_counter_hms.sv
// HH:MM:SS BCD time-of-day counter driven by an external 1 Hz strobe.
//   clk, rst          : clock, async active-low reset
//   pulse_1s          : 1 Hz strobe, rising edge counts one second
//   enable_count      : 1 = run, 0 = hold
//   load, load_hh/mm/ss : one-cycle request to load a BCD time
//   sec/min/hour_bcd  : current time, packed BCD
//   min_tick, day_tick: one-cycle strobes on minute and day wrap
//   load_ack, load_err: one-cycle load accepted / rejected
//   running           : high while in RUN
// HOUR_MAX must be 24 or 12; SYNC_STAGES must be 0 (same domain) or >= 2.
module time_counter_hms
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MAX    = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_1s,
    input  logic             enable_count,
    input  logic             load,
    input  logic [BCD_W-1:0] load_hh,
    input  logic [BCD_W-1:0] load_mm,
    input  logic [BCD_W-1:0] load_ss,
    output logic [BCD_W-1:0] sec_bcd,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] hour_bcd,
    output logic             min_tick,
    output logic             day_tick,
    output logic             load_ack,
    output logic             load_err,
    output logic             running
);

    localparam logic [BCD_W-1:0] HOUR_LAST = to_bcd8(HOUR_MAX - 1);

    logic   w_sync;
    logic   w_sync_vld;
    logic   r_pulse_d;
    logic   r_hist_vld;
    logic   w_tick;
    logic   w_load_ok;
    logic   w_load_wr;
    logic   w_inc_sec;
    logic   w_sec_wrap;
    logic   w_min_wrap;
    logic   w_hour_wrap;
    state_e r_state;
    logic   r_min_tick;
    logic   r_day_tick;
    logic   r_load_ack;
    logic   r_load_err;
    logic   r_running;

    // Strobe synchroniser; a parallel valid chain marks samples taken after reset release.
    if (SYNC_STAGES == 0) begin : g_direct
        assign w_sync     = pulse_1s;
        assign w_sync_vld = 1'b1;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        logic [SYNC_STAGES-1:0] r_vld;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync <= '0;
                r_vld  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_1s};
                r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            end
        end
        assign w_sync     = r_sync[SYNC_STAGES-1];
        assign w_sync_vld = r_vld[SYNC_STAGES-1];
    end

    // Edge history; a strobe already high at reset release never produces a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse_d  <= 1'b0;
            r_hist_vld <= 1'b0;
        end else begin
            r_pulse_d  <= w_sync;
            r_hist_vld <= w_sync_vld;
        end
    end

    assign w_tick    = w_sync & ~r_pulse_d & r_hist_vld & w_sync_vld;
    assign w_load_ok = bcd_le(load_ss, BCD_59) & bcd_le(load_mm, BCD_59) & bcd_le(load_hh, HOUR_LAST);
    assign w_load_wr = load & w_load_ok;
    // Ticks only count in RUN and lose to a simultaneous load.
    assign w_inc_sec = (r_state == ST_RUN) & w_tick & ~load;

    bcd_digit_pair u_sec (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_inc      (w_inc_sec),
        .i_load     (w_load_wr),
        .i_load_val (load_ss),
        .i_max_val  (BCD_59),
        .o_value    (sec_bcd),
        .o_wrap_c   (w_sec_wrap)
    );

    bcd_digit_pair u_min (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_inc      (w_sec_wrap),
        .i_load     (w_load_wr),
        .i_load_val (load_mm),
        .i_max_val  (BCD_59),
        .o_value    (min_bcd),
        .o_wrap_c   (w_min_wrap)
    );

    bcd_digit_pair u_hour (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_inc      (w_min_wrap),
        .i_load     (w_load_wr),
        .i_load_val (load_hh),
        .i_max_val  (HOUR_LAST),
        .o_value    (hour_bcd),
        .o_wrap_c   (w_hour_wrap)
    );

    // Control FSM with registered status outputs; load preempts every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_STOP;
            r_running  <= 1'b0;
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
            r_min_tick <= w_sec_wrap;
            r_day_tick <= w_hour_wrap;
            if (load) begin
                r_state    <= ST_LOAD;
                r_running  <= 1'b0;
                r_load_ack <= w_load_ok;
                r_load_err <= ~w_load_ok;
            end else begin
                case (r_state)
                    ST_STOP: begin
                        if (enable_count) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!enable_count) begin
                            r_state   <= ST_STOP;
                            r_running <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        r_state   <= enable_count ? ST_RUN : ST_STOP;
                        r_running <= enable_count;
                    end
                    default: begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign min_tick = r_min_tick;
    assign day_tick = r_day_tick;
    assign load_ack = r_load_ack;
    assign load_err = r_load_err;
    assign running  = r_running;

endmodule

// File: tb/tb_time_counter_hms.sv
// Directed bench for time_counter_hms: a 24-hour and a 12-hour instance share stimulus.
module tb_time_counter_hms;

    logic       clk;
    logic       rst;
    logic       pulse_1s;
    logic       enable_count;
    logic       load;
    logic [7:0] load_hh, load_mm, load_ss;

    logic [7:0] sec24, min24, hour24;
    logic       mtick24, dtick24, ack24, err24, run24;
    logic [7:0] sec12, min12, hour12;
    logic       mtick12, dtick12, ack12, err12, run12;

    int n_total;
    int n_bad;

    time_counter_hms #(.HOUR_MAX(24), .SYNC_STAGES(2)) dut24 (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s), .enable_count(enable_count),
        .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .sec_bcd(sec24), .min_bcd(min24), .hour_bcd(hour24),
        .min_tick(mtick24), .day_tick(dtick24),
        .load_ack(ack24), .load_err(err24), .running(run24)
    );

    time_counter_hms #(.HOUR_MAX(12), .SYNC_STAGES(2)) dut12 (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s), .enable_count(enable_count),
        .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12),
        .min_tick(mtick12), .day_tick(dtick12),
        .load_ack(ack12), .load_err(err12), .running(run12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; the count is visible three edges after the strobe rises.
    task automatic strobe1();
        pulse_1s = 1'b1;
        step(1);
        pulse_1s = 1'b0;
        step(2);
    endtask

    task automatic load_start(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        load_hh = hh;
        load_mm = mm;
        load_ss = ss;
        load    = 1'b1;
        step(1);
    endtask

    task automatic load_end();
        load = 1'b0;
        step(1);
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b0;
        pulse_1s     = 1'b0;
        enable_count = 1'b0;
        load         = 1'b0;
        load_hh      = 8'h00;
        load_mm      = 8'h00;
        load_ss      = 8'h00;

        // Reset state
        #1;
        check("rst_sec", sec24, 8'h00);
        check("rst_hour", hour24, 8'h00);
        check("rst_running", 8'(run24), 8'h00);
        check("rst_ticks", 8'({mtick24, dtick24, ack24, err24}), 8'h00);
        step(2);
        rst = 1'b1;
        enable_count = 1'b1;
        step(1);
        check("run_after_enable", 8'(run24), 8'h01);

        // Three single-cycle strobes
        strobe1();
        check("count_1", sec24, 8'h01);
        strobe1();
        check("count_2", sec24, 8'h02);
        strobe1();
        check("count_3", sec24, 8'h03);
        check("count_no_ticks", 8'({mtick24, dtick24}), 8'h00);
        check("count_running", 8'(run24), 8'h01);

        // Minute wrap from 00:00:59
        load_start(8'h00, 8'h00, 8'h59);
        check("ld59_ack", 8'(ack24), 8'h01);
        check("ld59_err", 8'(err24), 8'h00);
        check("ld59_sec", sec24, 8'h59);
        check("ld59_running_in_load", 8'(run24), 8'h00);
        load_end();
        check("ld59_ack_gone", 8'(ack24), 8'h00);
        check("ld59_back_to_run", 8'(run24), 8'h01);
        strobe1();
        check("minwrap_sec", sec24, 8'h00);
        check("minwrap_min", min24, 8'h01);
        check("minwrap_mtick", 8'(mtick24), 8'h01);
        check("minwrap_dtick", 8'(dtick24), 8'h00);
        step(1);
        check("minwrap_mtick_1cyc", 8'(mtick24), 8'h00);

        // Day wrap from 23:59:59 (rejected by the 12-hour instance)
        load_start(8'h23, 8'h59, 8'h59);
        check("ld23_ack24", 8'(ack24), 8'h01);
        check("ld23_err12", 8'(err12), 8'h01);
        check("ld23_ack12", 8'(ack12), 8'h00);
        check("ld23_min12_kept", min12, 8'h01);
        load_end();
        strobe1();
        check("day24_sec", sec24, 8'h00);
        check("day24_min", min24, 8'h00);
        check("day24_hour", hour24, 8'h00);
        check("day24_ticks", 8'({mtick24, dtick24}), 8'h03);
        check("day24_12h_sec", sec12, 8'h01);
        step(1);
        check("day24_dtick_1cyc", 8'(dtick24), 8'h00);

        // Day wrap from 11:59:59 on the 12-hour instance
        load_start(8'h11, 8'h59, 8'h59);
        check("ld11_ack12", 8'(ack12), 8'h01);
        load_end();
        strobe1();
        check("day12_sec", sec12, 8'h00);
        check("day12_min", min12, 8'h00);
        check("day12_hour", hour12, 8'h00);
        check("day12_ticks", 8'({mtick12, dtick12}), 8'h03);
        check("noon24_hour", hour24, 8'h12);
        check("noon24_ticks", 8'({mtick24, dtick24}), 8'h02);
        step(1);
        check("day12_dtick_1cyc", 8'(dtick12), 8'h00);

        // Invalid loads leave 12:00:00 untouched
        load_start(8'h01, 8'h02, 8'h5A);
        check("bad_ss_err", 8'(err24), 8'h01);
        check("bad_ss_ack", 8'(ack24), 8'h00);
        check("bad_ss_sec", sec24, 8'h00);
        check("bad_ss_min", min24, 8'h00);
        check("bad_ss_hour", hour24, 8'h12);
        load_end();
        check("bad_ss_err_1cyc", 8'(err24), 8'h00);
        load_start(8'h24, 8'h00, 8'h00);
        check("bad_hh_err", 8'(err24), 8'h01);
        check("bad_hh_ack", 8'(ack24), 8'h00);
        check("bad_hh_hour", hour24, 8'h12);
        load_end();

        // Strobe held for 5 cycles counts once
        pulse_1s = 1'b1;
        step(5);
        pulse_1s = 1'b0;
        step(3);
        check("held_sec", sec24, 8'h01);
        check("held_hour", hour24, 8'h12);

        // Tick coinciding with a valid load is dropped
        pulse_1s = 1'b1;
        step(2);
        load_start(8'h12, 8'h34, 8'h56);
        check("coinc_ack", 8'(ack24), 8'h01);
        check("coinc_sec", sec24, 8'h56);
        pulse_1s = 1'b0;
        load_end();
        step(3);
        check("coinc_sec_after", sec24, 8'h56);
        check("coinc_min", min24, 8'h34);
        check("coinc_running", 8'(run24), 8'h01);

        // Asynchronous reset mid-count
        rst = 1'b0;
        #1;
        check("async_sec", sec24, 8'h00);
        check("async_min", min24, 8'h00);
        check("async_hour", hour24, 8'h00);
        check("async_running", 8'(run24), 8'h00);
        step(1);
        rst = 1'b1;
        step(1);

        // enable dropped in the tick cycle: tick applied, then STOP
        load_start(8'h00, 8'h00, 8'h10);
        load_end();
        check("ld10_running", 8'(run24), 8'h01);
        pulse_1s = 1'b1;
        step(2);
        enable_count = 1'b0;
        pulse_1s = 1'b0;
        step(1);
        check("drop_sec", sec24, 8'h11);
        check("drop_running", 8'(run24), 8'h00);

        // Strobes while stopped are ignored
        strobe1();
        strobe1();
        step(2);
        check("stop_sec", sec24, 8'h11);
        check("stop_running", 8'(run24), 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
